// File: rtl/registro_universal.sv
// Universal N-bit register: parallel load, clear, and shift/rotate by amt, one bit per clock.
// Latency: 1 edge for HOLD/LOAD/CLR or amt<=1; amt edges (including the accept edge) for shifts.
// Backpressure: start is ignored while busy=1; a start in the done cycle is accepted back-to-back.
//
// Ports:
//   clk, clear     clock and synchronous active-high reset (clear beats start and shifting)
//   start, op, x, amt   request, op-code, load data, shift amount; sampled when busy=0
//   sin            serial fill bit for SHL/SHR, sampled on every shift edge
//   z, busy, done, cout register contents, shift in progress, completion pulse, last bit out
module registro_universal #(
  parameter int N   = 8,
  parameter int SHW = 3
) (
  input  logic           clk,
  input  logic           clear,
  input  logic           start,
  input  logic [2:0]     op,
  input  logic [N-1:0]   x,
  input  logic [SHW-1:0] amt,
  input  logic           sin,
  output logic [N-1:0]   z,
  output logic           busy,
  output logic           done,
  output logic           cout
);

  localparam logic [2:0] OP_HOLD = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_SHL  = 3'b010;
  localparam logic [2:0] OP_SHR  = 3'b011;
  localparam logic [2:0] OP_ROL  = 3'b100;
  localparam logic [2:0] OP_ROR  = 3'b101;
  localparam logic [2:0] OP_ASR  = 3'b110;
  localparam logic [2:0] OP_CLR  = 3'b111;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]     state;
  logic [2:0]     op_q;
  logic [SHW-1:0] cnt;
  logic [N-1:0]   z_q;
  logic           cout_q;
  logic           done_q;

  // One-position shift of v under op o; result is {carry_out, new_value}.
  function automatic logic [N:0] shift1(input logic [2:0] o, input logic [N-1:0] v,
                                        input logic s);
    logic [N:0] r;
    r = {1'b0, v};
    case (o)
      OP_SHL:  r = {v[N-1], v[N-2:0], s};
      OP_SHR:  r = {v[0], s, v[N-1:1]};
      OP_ROL:  r = {v[N-1], v[N-2:0], v[N-1]};
      OP_ROR:  r = {v[0], v[0], v[N-1:1]};
      OP_ASR:  r = {v[0], v[N-1], v[N-1:1]};
      default: r = {1'b0, v};
    endcase
    return r;
  endfunction

  logic [2:0]   op_sel;
  logic [N:0]   sh_res;
  logic         op_is_shift;

  // In IDLE the first shift happens on the accept edge, so use the live op;
  // in SHIFT keep using the op latched at accept time.
  always_comb begin
    op_sel      = (state == IDLE) ? op : op_q;
    sh_res      = shift1(op_sel, z_q, sin);
    op_is_shift = (op != OP_HOLD) && (op != OP_LOAD) && (op != OP_CLR);
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state  <= IDLE;
      op_q   <= OP_HOLD;
      cnt    <= '0;
      z_q    <= '0;
      cout_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_q <= op;
            if (!op_is_shift) begin
              if (op == OP_LOAD)     z_q <= x;
              else if (op == OP_CLR) z_q <= '0;
              done_q <= 1'b1;
            end else if (amt == '0) begin
              done_q <= 1'b1;
            end else begin
              z_q    <= sh_res[N-1:0];
              cout_q <= sh_res[N];
              if (amt == SHW'(1)) begin
                done_q <= 1'b1;
              end else begin
                cnt   <= amt - SHW'(1);
                state <= SHIFT;
              end
            end
          end
        end
        default: begin
          z_q    <= sh_res[N-1:0];
          cout_q <= sh_res[N];
          cnt    <= cnt - SHW'(1);
          if (cnt == SHW'(1)) begin
            state  <= IDLE;
            done_q <= 1'b1;
          end
        end
      endcase
    end
  end

  assign z    = z_q;
  assign cout = cout_q;
  assign done = done_q;
  assign busy = (state == SHIFT);

endmodule

// File: tb/tb_registro_universal.sv
// Directed bench for registro_universal (N=8, SHW=3).
// Inputs change 1 time unit after each rising edge; outputs are checked at the same point.
// Each check reports tag, observed and expected values on mismatch.
module tb_registro_universal;

  logic       clk;
  logic       clear;
  logic       start;
  logic [2:0] op;
  logic [7:0] x;
  logic [2:0] amt;
  logic       sin;
  logic [7:0] z;
  logic       busy;
  logic       done;
  logic       cout;

  int checks = 0;
  int errors = 0;

  registro_universal #(.N(8), .SHW(3)) dut (
    .clk   (clk),
    .clear (clear),
    .start (start),
    .op    (op),
    .x     (x),
    .amt   (amt),
    .sin   (sin),
    .z     (z),
    .busy  (busy),
    .done  (done),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] ez, input logic eb,
                         input logic ed, input logic ec);
    chk({tag, ".z"},    {24'd0, z},    {24'd0, ez});
    chk({tag, ".busy"}, {31'd0, busy}, {31'd0, eb});
    chk({tag, ".done"}, {31'd0, done}, {31'd0, ed});
    chk({tag, ".cout"}, {31'd0, cout}, {31'd0, ec});
  endtask

  initial begin
    clear = 1'b1; start = 1'b0; op = 3'b000; x = 8'h00; amt = 3'd0; sin = 1'b0;
    tick();
    tick();
    chk_all("reset", 8'h00, 1'b0, 1'b0, 1'b0);
    clear = 1'b0;

    // LOAD A5: single cycle, done pulse, never busy
    start = 1'b1; op = 3'b001; x = 8'hA5;
    tick();
    start = 1'b0;
    chk_all("loadA5", 8'hA5, 1'b0, 1'b1, 1'b0);
    tick();
    chk_all("loadA5_after", 8'hA5, 1'b0, 1'b0, 1'b0);

    // LOAD 81 then SHL amt=3 sin=1 back-to-back in the done cycle
    start = 1'b1; op = 3'b001; x = 8'h81;
    tick();
    chk_all("load81", 8'h81, 1'b0, 1'b1, 1'b0);
    op = 3'b010; amt = 3'd3; sin = 1'b1;
    tick();
    start = 1'b0;
    chk_all("shl_e1", 8'h03, 1'b1, 1'b0, 1'b1);
    tick();
    chk_all("shl_e2", 8'h07, 1'b1, 1'b0, 1'b0);
    tick();
    chk_all("shl_e3", 8'h0F, 1'b0, 1'b1, 1'b0);
    tick();
    chk_all("shl_idle", 8'h0F, 1'b0, 1'b0, 1'b0);

    // LOAD 81, ROR amt=1
    start = 1'b1; op = 3'b001; x = 8'h81; sin = 1'b0;
    tick();
    op = 3'b101; amt = 3'd1;
    tick();
    start = 1'b0;
    chk_all("ror1", 8'hC0, 1'b0, 1'b1, 1'b1);
    tick();
    chk_all("ror1_after", 8'hC0, 1'b0, 1'b0, 1'b1);

    // LOAD 80, ASR amt=7, with a LOAD FF attempt during SHIFT
    start = 1'b1; op = 3'b001; x = 8'h80;
    tick();
    op = 3'b110; amt = 3'd7; sin = 1'b1;
    tick();
    start = 1'b0;
    chk_all("asr_e1", 8'hC0, 1'b1, 1'b0, 1'b0);
    tick();
    chk_all("asr_e2", 8'hE0, 1'b1, 1'b0, 1'b0);
    start = 1'b1; op = 3'b001; x = 8'hFF; amt = 3'd0;
    tick();
    start = 1'b0;
    chk_all("asr_e3_ignore", 8'hF0, 1'b1, 1'b0, 1'b0);
    tick();
    tick();
    tick();
    chk_all("asr_e6", 8'hFE, 1'b1, 1'b0, 1'b0);
    // At done, start LOAD 3C
    start = 1'b1; op = 3'b001; x = 8'h3C;
    tick();
    chk_all("asr_e7", 8'hFF, 1'b0, 1'b1, 1'b0);
    tick();
    start = 1'b0;
    chk_all("load3C", 8'h3C, 1'b0, 1'b1, 1'b0);

    // LOAD C3, ROL amt=5, clear after 2 shifts
    start = 1'b1; op = 3'b001; x = 8'hC3;
    tick();
    op = 3'b100; amt = 3'd5;
    tick();
    start = 1'b0;
    chk_all("rol_e1", 8'h87, 1'b1, 1'b0, 1'b1);
    tick();
    chk_all("rol_e2", 8'h0F, 1'b1, 1'b0, 1'b1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk_all("clear_mid", 8'h00, 1'b0, 1'b0, 1'b0);
    tick();
    chk_all("clear_stay", 8'h00, 1'b0, 1'b0, 1'b0);

    // Fresh ops after clear
    start = 1'b1; op = 3'b001; x = 8'h5A;
    tick();
    chk_all("fresh_load", 8'h5A, 1'b0, 1'b1, 1'b0);
    op = 3'b100; amt = 3'd0;
    tick();
    chk_all("rol_amt0", 8'h5A, 1'b0, 1'b1, 1'b0);
    op = 3'b011; amt = 3'd2; sin = 1'b1;
    tick();
    start = 1'b0;
    chk_all("shr_e1", 8'hAD, 1'b1, 1'b0, 1'b0);
    tick();
    chk_all("shr_e2", 8'hD6, 1'b0, 1'b1, 1'b1);
    start = 1'b1; op = 3'b111;
    tick();
    start = 1'b0;
    chk_all("clr_op", 8'h00, 1'b0, 1'b1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
